// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one shared debounce engine feeding a small key-code FIFO.
// Optional build macro KEYPAD_RELEASE_EVT_EN adds release events (key_code[4]=1).
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 8,
    parameter int DEBOUNCE_CNT = 4096,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [3:0]                    col,
    output logic [3:0]                    row,
    output logic [4:0]                    key_code,
    output logic                          key_valid,
    input  logic                          key_pop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          key_irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);

    typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_HOLD} state_t;

    logic [3:0]    col_m_q, col_s_q;
    state_t        state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    row_q;
    logic [1:0]    col_idx;
    logic          push;
    logic [4:0]    push_code;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic [3:0]    held_q, held_d;
`endif

    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overflow_q, overflow_d;
    logic          do_pop, do_push, full;

    // Multi-key patterns report only the lowest active column.
    always_comb begin
        col_idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!pat_q[i]) col_idx = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        pat_d     = pat_q;
        push      = 1'b0;
        push_code = {1'b0, row_idx_q, col_idx};
`ifdef KEYPAD_RELEASE_EVT_EN
        held_d    = held_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (col_s_q == 4'hF) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        pat_d   = col_s_q;
                        deb_d   = '0;
                        state_d = ST_DEB;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_DEB: begin
                if (col_s_q != pat_q) begin
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = ST_SCAN;
                end else if (deb_q == BW'(DEBOUNCE_CNT - 1)) begin
                    push    = 1'b1;
                    deb_d   = '0;
                    state_d = ST_HOLD;
`ifdef KEYPAD_RELEASE_EVT_EN
                    held_d  = {row_idx_q, col_idx};
`endif
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end
            ST_HOLD: begin
                if (col_s_q != 4'hF) begin
                    deb_d = '0;
                end else if (deb_q == BW'(DEBOUNCE_CNT - 1)) begin
                    deb_d     = '0;
                    dwell_d   = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = ST_SCAN;
`ifdef KEYPAD_RELEASE_EVT_EN
                    push      = 1'b1;
                    push_code = {1'b1, held_q};
`endif
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Head is registered from the post-update FIFO, so a same-cycle write is bypassed.
    always_comb begin
        full    = (cnt_q == CW'(FIFO_DEPTH));
        do_pop  = key_pop && (cnt_q != '0);
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_code;
        wr_d        = do_push ? wr_q + PW'(1) : wr_q;
        rd_d        = do_pop  ? rd_q + PW'(1) : rd_q;
        cnt_d       = cnt_q + CW'(do_push) - CW'(do_pop);
        key_valid_d = (cnt_d != '0);
        key_code_d  = key_valid_d ? mem_d[rd_d] : 5'd0;
        if (push && full && !do_pop) overflow_d = 1'b1;
        else if (overflow_clr)       overflow_d = 1'b0;
        else                         overflow_d = overflow_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_m_q     <= 4'hF;
            col_s_q     <= 4'hF;
            state_q     <= ST_SCAN;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            pat_q       <= 4'hF;
            row_q       <= 4'b1110;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            key_code_q  <= 5'd0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
`ifdef KEYPAD_RELEASE_EVT_EN
            held_q      <= 4'd0;
`endif
        end else begin
            col_m_q     <= col;
            col_s_q     <= col_m_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            pat_q       <= pat_d;
            row_q       <= ~(4'b0001 << row_idx_d);
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef KEYPAD_RELEASE_EVT_EN
            held_q      <= held_d;
`endif
        end
    end

    assign row        = row_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_irq    = key_valid_q;
    assign fifo_count = cnt_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: queue-based reference model checked every cycle plus directed literals.
module tb_keypad_scan_ctrl;
    localparam int SD = 8;
    localparam int DC = 16;
    localparam int FD = 4;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] col = 4'hF;
    logic [3:0] row;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_pop = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic       key_irq;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .FIFO_DEPTH(FD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .col(col), .row(row), .key_code(key_code),
        .key_valid(key_valid), .key_pop(key_pop), .fifo_count(fifo_count),
        .overflow(overflow), .overflow_clr(overflow_clr), .key_irq(key_irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 scanning, 1 confirming a press, 2 waiting for release.
    int         m_mode = 0, m_ridx = 0, m_timer = 0, m_deb = 0;
    logic [3:0] m_pat = 4'hF, m_key = 4'h0, ms1 = 4'hF, ms = 4'hF;
    logic [4:0] mq[$];
    logic       m_ov = 1'b0;

    function automatic logic [1:0] lowest0(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (!p[i]) return 2'(i);
        return 2'd3;
    endfunction

    function automatic bit m_push_next();
        return (m_mode == 1) && (m_deb == DC - 1) && (ms == m_pat);
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        logic [4:0] ev;
        bit has_ev, dropped;
        if (!HRESETn) begin
            m_mode = 0; m_ridx = 0; m_timer = 0; m_deb = 0;
            m_pat = 4'hF; ms1 = 4'hF; ms = 4'hF; m_ov = 1'b0;
            mq.delete();
        end else begin
            has_ev = 0; dropped = 0; ev = 5'd0;
            if (m_mode == 0) begin
                if (m_timer == SD - 1) begin
                    m_timer = 0;
                    if (ms == 4'hF) m_ridx = (m_ridx + 1) % 4;
                    else begin m_pat = ms; m_deb = 0; m_mode = 1; end
                end else m_timer++;
            end else if (m_mode == 1) begin
                if (ms != m_pat) begin
                    m_ridx = (m_ridx + 1) % 4; m_mode = 0;
                end else if (m_deb == DC - 1) begin
                    m_key = {2'(m_ridx), lowest0(m_pat)};
                    ev = {1'b0, m_key}; has_ev = 1; m_deb = 0; m_mode = 2;
                end else m_deb++;
            end else begin
                if (ms != 4'hF) m_deb = 0;
                else if (m_deb == DC - 1) begin
                    m_deb = 0; m_timer = 0; m_ridx = (m_ridx + 1) % 4; m_mode = 0;
`ifdef KEYPAD_RELEASE_EVT_EN
                    ev = {1'b1, m_key}; has_ev = 1;
`endif
                end else m_deb++;
            end
            if (key_pop && mq.size() > 0) void'(mq.pop_front());
            if (has_ev) begin
                if (mq.size() < FD) mq.push_back(ev);
                else dropped = 1;
            end
            if (dropped) m_ov = 1'b1;
            else if (overflow_clr) m_ov = 1'b0;
            ms = ms1; ms1 = col;
        end
    end

    always begin
        logic [3:0] er;
        logic [4:0] ec;
        @(posedge HCLK);
        #2;
        er = ~(4'b0001 << m_ridx);
        ec = (mq.size() > 0) ? mq[0] : 5'd0;
        chk("row", row, er);
        chk("key_valid", key_valid, (mq.size() > 0));
        chk("key_irq", key_irq, (mq.size() > 0));
        chk("key_code", key_code, ec);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ov);
    end

    function automatic logic [3:0] rowval(input int r);
        logic [3:0] v;
        v = ~(4'b0001 << r);
        return v;
    endfunction

    task automatic wait_row(input int r);
        int n;
        n = 0;
        while (row == rowval(r) && n < 200) begin @(negedge HCLK); n++; end
        while (row != rowval(r) && n < 200) begin @(negedge HCLK); n++; end
        if (n >= 200) chk("wait_row_timeout", 0, 1);
    endtask

    task automatic press(input int r, input int c, input bit pop_at_push);
        wait_row(r);
        col = ~(4'b0001 << c);
        for (int i = 0; i < 40; i++) begin
            if (pop_at_push && m_push_next()) key_pop = 1'b1;
            @(negedge HCLK);
            key_pop = 1'b0;
        end
        col = 4'hF;
        repeat (30) @(negedge HCLK);
    endtask

    task automatic pop_one();
        key_pop = 1'b1;
        @(negedge HCLK);
        key_pop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_row"}, row, 4'b1110);
        chk({tag, "_valid"}, key_valid, 0);
        chk({tag, "_code"}, key_code, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_irq"}, key_irq, 0);
    endtask

    initial begin
        int n;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        HRESETn = 1'b1;

        // Idle scan: row index k/8 mod 4 after k clock edges.
        for (int k = 0; k < 40; k++) begin
            if (k % 8 == 0 || k % 8 == 7) chk("scan_row", row, rowval((k / 8) % 4));
            @(negedge HCLK);
        end
        chk("idle_valid", key_valid, 0);

        press(2, 2, 0);
        chk("p1_code", key_code, 5'h0A);
        chk("p1_valid", key_valid, 1);
        chk("p1_irq", key_irq, 1);
`ifdef KEYPAD_RELEASE_EVT_EN
        chk("p1_count", fifo_count, 2);
        pop_one();
        chk("p1_rel_code", key_code, 5'h1A);
        pop_one();
`else
        chk("p1_count", fifo_count, 1);
        pop_one();
`endif
        chk("p1_pop_valid", key_valid, 0);
        chk("p1_pop_count", fifo_count, 0);

        for (int i = 0; i < 200; i++) begin
            col = ((i / 5) % 2 == 0) ? 4'b1101 : 4'hF;
            @(negedge HCLK);
        end
        col = 4'hF;
        repeat (30) @(negedge HCLK);
        chk("bounce_count", fifo_count, 0);

        press(0, 0, 0);
        press(1, 1, 0);
        press(2, 3, 0);
        press(3, 2, 0);
        press(1, 0, 0);
        chk("full_count", fifo_count, 4);
        chk("full_ovf", overflow, 1);
        overflow_clr = 1'b1;
        @(negedge HCLK);
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        press(0, 3, 1);
`ifndef KEYPAD_RELEASE_EVT_EN
        chk("pp_count", fifo_count, 4);
        chk("pp_ovf", overflow, 0);
        begin
            logic [4:0] exp_q [4];
            exp_q = '{5'h05, 5'h0B, 5'h0E, 5'h03};
            for (int i = 0; i < 4; i++) begin
                chk("pp_order", key_code, exp_q[i]);
                pop_one();
            end
        end
`endif
        n = 0;
        while (key_valid && n < 8) begin pop_one(); n++; end
        chk("drain_count", fifo_count, 0);
        overflow_clr = 1'b1;
        @(negedge HCLK);
        overflow_clr = 1'b0;

        press(3, 0, 0);
        chk("r3c0_code", key_code, 5'h0C);
`ifdef KEYPAD_RELEASE_EVT_EN
        chk("r3c0_count", fifo_count, 2);
        pop_one();
        chk("r3c0_rel", key_code, 5'h1C);
`else
        chk("r3c0_count", fifo_count, 1);
`endif
        pop_one();
        chk("r3c0_empty", key_valid, 0);

        // Reset while a key is held must drop everything.
        wait_row(1);
        col = 4'b1011;
        n = 0;
        while (m_mode != 2 && n < 100) begin @(negedge HCLK); n++; end
        if (n >= 100) chk("hold_wait_timeout", 0, 1);
        repeat (3) @(negedge HCLK);
        chk("prehold_valid", key_valid, 1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check_reset_outputs("midhold");
        col = 4'hF;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (40) @(negedge HCLK);
        chk("post_reset_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
